// File: rtl/nn_output_collector.sv
// ---------------------------------------------------------------------------
// nn_output_collector
//
// Collects the N_OUT signed result beats of one inference frame and reports
// the winner (argmax) to the host. The accepted beat sequence is reduced on
// the fly, so no frame buffer is needed: every beat is compared against the
// best score seen so far. The comparison is signed and strict, so on a tie
// the lowest index wins.
//
// The control is a two-state Moore FSM:
//   COLLECT : in_ready=1, out_valid=0, beats are accepted
//   PRESENT : in_ready=0, out_valid=1, the result is held until out_ready
// in_ready and out_valid depend only on the state, never on the inputs.
//
// Parameters
//   DATA_W   signed score width of each result beat
//   N_OUT    beats per frame (2..16)
//   TIMEOUT  idle-cycle limit for a partial frame (1..255, watchdog only)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   result beat valid from the accelerator output stage
//   in_data    signed result score
//   in_ready   collector accepts a beat (accelerator ready_out)
//   out_valid  classified frame available to the host
//   out_class  index of the winning neuron
//   out_score  winning signed score
//   out_ready  host accepts the frame
//   frame_cnt  completed frames handed to the host, wraps 255 -> 0
//   err        one-cycle pulse on a partial-frame timeout
//
// Build option
//   COLLECTOR_TIMEOUT_EN  when defined, a watchdog discards a partial frame
//                         after TIMEOUT idle cycles and pulses err. When it
//                         is undefined, err is tied low and a partial frame
//                         waits indefinitely.
// ---------------------------------------------------------------------------
module nn_output_collector #(
    parameter int DATA_W  = 8,
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [$clog2(N_OUT)-1:0] out_class,
    output logic [DATA_W-1:0]        out_score,
    input  logic                     out_ready,
    output logic [7:0]               frame_cnt,
    output logic                     err
);

    localparam int IDX_W = $clog2(N_OUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

    // Elaboration-time parameter range checks.
    if (N_OUT < 2 || N_OUT > 16) begin : g_bad_n_out
        $error("nn_output_collector: N_OUT must be in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("nn_output_collector: TIMEOUT must be in 1..255");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         idx_nxt;
    logic [IDX_W-1:0]         best_idx;
    logic [IDX_W-1:0]         best_idx_nxt;
    logic signed [DATA_W-1:0] best_score;
    logic signed [DATA_W-1:0] best_score_nxt;
    logic [IDX_W-1:0]         class_q;
    logic [DATA_W-1:0]        score_q;

    logic accept;       // beat handshake this cycle
    logic last_beat;    // accepted beat completes the frame
    logic take;         // accepted beat becomes the new best
    logic handoff;      // host takes the presented frame
    logic timeout_hit;  // watchdog fires this cycle

    // ------------------------------------------------------------------
    // Moore outputs: decoded from state only.
    // ------------------------------------------------------------------
    assign in_ready  = (state == COLLECT);
    assign out_valid = (state == PRESENT);
    assign out_class = class_q;
    assign out_score = score_q;

    // ------------------------------------------------------------------
    // Next-state and datapath decode.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        idx_nxt        = idx;
        best_idx_nxt   = best_idx;
        best_score_nxt = best_score;

        accept    = in_ready && in_valid;
        last_beat = accept && (idx == LAST_IDX);
        handoff   = (state == PRESENT) && out_ready;

        // First beat of a frame always loads; later beats only on a strictly
        // greater signed score, which keeps the lowest index on ties.
        take = accept && ((idx == '0) || ($signed(in_data) > best_score));

        if (take) begin
            best_score_nxt = $signed(in_data);
            best_idx_nxt   = idx;
        end

        if (accept) begin
            idx_nxt = last_beat ? '0 : idx + 1'b1;
        end else if (timeout_hit) begin
            idx_nxt = '0;
        end

        if (last_beat) begin
            state_nxt = PRESENT;
        end else if (handoff) begin
            state_nxt = COLLECT;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= COLLECT;
            idx        <= '0;
            best_idx   <= '0;
            best_score <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            best_idx   <= best_idx_nxt;
            best_score <= best_score_nxt;
        end
    end

    // The presented result is captured from the next-best values on the
    // final beat, so out_valid and the result appear together one cycle
    // after the last beat. Holding a copy keeps out_class/out_score at the
    // last presented values while the next frame is being reduced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            class_q <= '0;
            score_q <= '0;
        end else if (last_beat) begin
            class_q <= best_idx_nxt;
            score_q <= best_score_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (handoff) begin
            frame_cnt <= frame_cnt + 8'd1;  // natural 8-bit wrap
        end
    end

    // ------------------------------------------------------------------
    // Partial-frame watchdog.
    // ------------------------------------------------------------------
`ifdef COLLECTOR_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       err_q;
    logic       idle;

    // Idle means a frame is partly collected and no beat arrives.
    assign idle = (state == COLLECT) && (idx != '0) && !accept;

    // Fires on the cycle the counter would reach TIMEOUT. An accepted beat
    // clears "idle", so a beat arriving on that cycle wins.
    assign timeout_hit = idle && (idle_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (accept || timeout_hit) begin
                idle_cnt <= '0;
            end else if (idle) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

endmodule

// File: doc/nn_output_collector.md
NN_OUTPUT_COLLECTOR -- requirements
Module: nn_output_collector

Interface
REQ-001 Parameter DATA_W, 8, signed score width of each result beat.
REQ-002 Parameter N_OUT, 4, result beats per frame (one per output neuron), range 2..16.
REQ-003 Parameter TIMEOUT, 255, idle-cycle limit for a partial frame (used only with COLLECTOR_TIMEOUT_EN).
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  result beat valid from accelerator output stage.
REQ-007 in_data  input  DATA_W  signed result score.
REQ-008 in_ready  output  1  collector can accept a beat; drives the accelerator's ready_out.
REQ-009 out_valid  output  1  classified frame available to host.
REQ-010 out_class  output  $clog2(N_OUT)  index of winning neuron.
REQ-011 out_score  output  DATA_W  winning signed score.
REQ-012 out_ready  input  1  host accepts frame.
REQ-013 frame_cnt  output  8  completed frames handed to host, wraps 255->0.
REQ-014 err  output  1  one-cycle pulse on partial-frame timeout.

Function
REQ-015 Moore FSM, states COLLECT and PRESENT; in_ready and out_valid decoded from state only, never from inputs.
REQ-016 COLLECT: in_ready=1, out_valid=0; PRESENT: in_ready=0, out_valid=1.
REQ-017 Beat accepted iff in_valid && in_ready at rising clk; idx (beat index) increments per accepted beat.
REQ-018 Beat with idx==0 unconditionally loads best_score<=in_data, best_idx<=0.
REQ-019 Beat with idx>0 loads best_score/best_idx only if in_data > best_score (signed, strict); ties keep lowest index.
REQ-020 Accepted beat with idx==N_OUT-1: idx<=0, next state PRESENT; out_valid high the following cycle (latency 1 from last beat).
REQ-021 PRESENT: out_class=best_idx, out_score=best_score held stable until handshake.
REQ-022 PRESENT with out_ready=1: frame_cnt increments (modulo 256), next state COLLECT; in_ready high the following cycle.
REQ-023 PRESENT with out_ready=0: remain, all outputs unchanged; in_valid ignored (backpressure to accelerator).
REQ-024 out_class/out_score in COLLECT hold last presented values (don't-care for host, but no X after reset).
REQ-025 err=0 at all times except as defined in REQ-030.

Reset
REQ-026 reset asserted: state=COLLECT, idx=0, best_score=0, best_idx=0, frame_cnt=0, timeout counter=0, err=0, immediately and asynchronously.
REQ-027 Reset outputs: in_ready=1, out_valid=0, out_class=0, out_score=0, frame_cnt=0, err=0.
REQ-028 reset mid-frame or in PRESENT discards partial/pending frame; no frame_cnt increment.

Configuration
REQ-029 Macro COLLECTOR_TIMEOUT_EN selects partial-frame watchdog.
REQ-030 Defined: 8-bit counter counts cycles in COLLECT with idx!=0 and no accepted beat, clears on each accepted beat; on reaching TIMEOUT: idx<=0, counter<=0, err pulses 1 for one cycle, state stays COLLECT, frame_cnt unchanged.
REQ-031 Beat accepted in same cycle counter would reach TIMEOUT: beat wins, no timeout.
REQ-032 Undefined: no counter logic; err port present, tied 0; partial frame waits indefinitely.

Verification
REQ-033 Reset then beats 5,-3,9,2 back-to-back (N_OUT=4) -> out_valid cycle after 4th beat, out_class=2, out_score=9, in_ready=0.
REQ-034 Beats -7,-7,-8,-9 -> out_class=0, out_score=-7 (tie lowest index, signed compare).
REQ-035 Hold out_ready=0 10 cycles with in_valid=1 -> outputs stable, no beats accepted; out_ready=1 -> frame_cnt=1, in_ready=1 next cycle.
REQ-036 256 frames with out_ready=1 -> frame_cnt wraps to 0.
REQ-037 Reset asserted after 2 beats -> in_ready=1, out_valid=0 immediately; next 4 beats 1,2,3,4 -> out_class=3.
REQ-038 With COLLECTOR_TIMEOUT_EN, TIMEOUT=255: 1 beat then 255 idle cycles -> err pulse, idx=0; next 4 beats form clean frame; without macro err stays 0.
